conveyor_writeback: RTL and testbench
=====================================

CONVEYOR_WRITEBACK -- requirements
Module: conveyor_writeback

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data word width.
REQ-002 Parameter CONVEYOR_ADDR_WIDTH, default 4, slot address width; CONVEYOR_SIZE = 2^CONVEYOR_ADDR_WIDTH.
REQ-003 Localparam FAULT_ADDR_WIDTH = 3; SLOT_WIDTH = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 alloc_valid  in  1  issue stage reserves a slot this cycle.
REQ-007 alloc_ready  out  1  reservation accepted when alloc_valid && alloc_ready.
REQ-008 alloc_conv  in  1  conveyor select (0 = main, 1 = interrupt).
REQ-009 alloc_addr  in  CONVEYOR_ADDR_WIDTH  slot to reserve.
REQ-010 p{0,1}_valid  in  1  producer N has a completed result.
REQ-011 p{0,1}_ready  out  1  producer N result accepted this cycle.
REQ-012 p{0,1}_conv / p{0,1}_addr  in  1 / CONVEYOR_ADDR_WIDTH  destination conveyor and slot.
REQ-013 p{0,1}_fault / p{0,1}_value  in  FAULT_ADDR_WIDTH / WORD_WIDTH  result fault code and value.
REQ-014 cv_busy  in  1  conveyor write port is taken next cycle by interrupt servicing.
REQ-015 wr_en / wr_conv / wr_addr  out  1 / 1 / CONVEYOR_ADDR_WIDTH  registered conveyor write strobe and target.
REQ-016 wr_slot  out  SLOT_WIDTH  {finished, fault, value} written to the target.
REQ-017 pending0 / pending1  out  CONVEYOR_ADDR_WIDTH+1  outstanding reservations per conveyor.
REQ-018 drained  out  1  both pending counts are 0 and wr_en is 0.
REQ-019 spurious  out  1  one-cycle pulse when a completion arrives for a conveyor whose pending count is 0.

Function
REQ-020 The block SHALL perform at most one conveyor write per cycle, wr_en registered, 1-cycle latency from acceptance.
REQ-021 Priority SHALL be: cv_busy (no accept) > alloc > producers.
REQ-022 alloc_ready SHALL = !cv_busy && pending[alloc_conv] != CONVEYOR_SIZE.
REQ-023 An accepted alloc SHALL write wr_slot = {0, F_NONE, 0} to (alloc_conv, alloc_addr).
REQ-024 Producers SHALL be accepted only when !cv_busy && !(alloc_valid && alloc_ready).
REQ-025 With one producer valid, that producer SHALL be granted; with both valid, the producer named by the round-robin pointer SHALL be granted.
REQ-026 After each producer grant, the pointer SHALL move to the other producer; it SHALL hold when there is no grant.
REQ-027 At most one p*_ready SHALL be high per cycle; ready SHALL never be high without a matching valid.
REQ-028 A granted completion SHALL write wr_slot = {1, pN_fault, pN_value} to (pN_conv, pN_addr).
REQ-029 pending[c] SHALL increment on an accepted alloc to c and decrement on an accepted completion to c.
REQ-030 Because alloc and completion are never accepted in the same cycle, a count SHALL change by at most 1 per cycle.
REQ-031 A completion to c with pending[c] == 0 SHALL still be written, SHALL leave the count at 0, and SHALL pulse spurious in the following cycle.
REQ-032 Slot addresses SHALL pass unmodified; wrap-around is the conveyor's concern; no address arithmetic is done here.

Reset
REQ-033 During reset, alloc_ready and p*_ready SHALL be 0 and no handshake SHALL be accepted.
REQ-034 On reset, wr_en, wr_conv, wr_addr, wr_slot, spurious, the pending counts and the round-robin pointer (producer 0) SHALL all be cleared to 0; drained reads 1 the cycle after.
REQ-035 Reset asserted mid-operation SHALL discard any in-flight write, so that wr_en = 0 the next cycle.

Structure
REQ-036 A shared package conveyor_pkg SHALL hold FAULT_ADDR_WIDTH, the SLOT_WIDTH formula and the slot packed struct {finished, fault, value}; F_NONE SHALL come from faults.sv.
REQ-037 The 2-way round-robin grant SHALL be the sub-module rr_arbiter2 (req[1:0], advance, grant[1:0], pointer register).

Verification
REQ-038 Alloc (conv 0, addr 5) -> next cycle wr_en = 1, addr 5, wr_slot = {0, 0, 0}; pending0 = 1; drained = 0.
REQ-039 p0 completes (0, 5, fault 0, 0xDEADBEEF) -> next cycle wr_slot = {1, 0, 0xDEADBEEF}; pending0 = 0; drained = 1 one cycle later.
REQ-040 p0 and p1 both valid for 4 cycles, pointer at 0 -> grants p0, p1, p0, p1; exactly one write per cycle.
REQ-041 alloc_valid, p0_valid and cv_busy all high -> no ready and no write; drop cv_busy -> alloc first, then p0.
REQ-042 16 allocs to conv 1 -> pending1 = 16 and alloc_ready = 0 for conv 1; one completion -> alloc_ready returns to 1.
REQ-043 Completion to conv 0 with pending0 = 0 -> write performed, spurious pulses once, pending0 stays 0; reset mid-write -> wr_en = 0 next cycle.

Source files
------------

// File: rtl/conveyor_pkg.sv
// Conveyor slot layout shared by the issue stage, writeback and the conveyor itself.
package conveyor_pkg;

  localparam int unsigned FAULT_ADDR_WIDTH   = 3;
  localparam int unsigned DEFAULT_WORD_WIDTH = 32;

  function automatic int unsigned slot_width(input int unsigned word_width);
    return 1 + FAULT_ADDR_WIDTH + word_width;
  endfunction

  // Reference layout at the default word width; modules with other widths
  // declare the same field order locally.
  typedef struct packed {
    logic                          finished;
    logic [FAULT_ADDR_WIDTH-1:0]   fault;
    logic [DEFAULT_WORD_WIDTH-1:0] value;
  } slot_t;

endpackage

// File: rtl/faults.sv
// Fault codes shared across the pipeline; a slot carrying F_NONE completed cleanly.
package faults;

  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_MISALIGN = 3'd1;
  localparam logic [2:0] F_ACCESS   = 3'd2;
  localparam logic [2:0] F_ILLEGAL  = 3'd3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; the pointer names who wins a tie and flips after each committed grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic pointer;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pointer <= 1'b0;
    end else if (advance && (grant != '0)) begin
      pointer <= grant[0];
    end
  end

endmodule

// File: rtl/conveyor_writeback.sv
// Single conveyor write port shared between slot reservation and two result producers.
module conveyor_writeback
  import conveyor_pkg::*;
  import faults::*;
#(
  parameter  int unsigned WORD_WIDTH          = 32,
  parameter  int unsigned CONVEYOR_ADDR_WIDTH = 4,
  localparam int unsigned CONVEYOR_SIZE       = 2 ** CONVEYOR_ADDR_WIDTH,
  localparam int unsigned SLOT_WIDTH          = slot_width(WORD_WIDTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic                           alloc_conv,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0] alloc_addr,
  input  logic                           p0_valid,
  output logic                           p0_ready,
  input  logic                           p0_conv,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0] p0_addr,
  input  logic [FAULT_ADDR_WIDTH-1:0]    p0_fault,
  input  logic [WORD_WIDTH-1:0]          p0_value,
  input  logic                           p1_valid,
  output logic                           p1_ready,
  input  logic                           p1_conv,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0] p1_addr,
  input  logic [FAULT_ADDR_WIDTH-1:0]    p1_fault,
  input  logic [WORD_WIDTH-1:0]          p1_value,
  input  logic                           cv_busy,
  output logic                           wr_en,
  output logic                           wr_conv,
  output logic [CONVEYOR_ADDR_WIDTH-1:0] wr_addr,
  output logic [SLOT_WIDTH-1:0]          wr_slot,
  output logic [CONVEYOR_ADDR_WIDTH:0]   pending0,
  output logic [CONVEYOR_ADDR_WIDTH:0]   pending1,
  output logic                           drained,
  output logic                           spurious
);

  localparam int unsigned CNT_W = CONVEYOR_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CONVEYOR_SIZE);

  typedef struct packed {
    logic                        finished;
    logic [FAULT_ADDR_WIDTH-1:0] fault;
    logic [WORD_WIDTH-1:0]       value;
  } wb_slot_t;

  wb_slot_t                     slot_q;
  logic                         alloc_take;
  logic                         prod_open;
  logic [1:0]                   req;
  logic [1:0]                   grant;
  logic                         comp_take;
  logic                         comp_conv;
  logic [CONVEYOR_ADDR_WIDTH-1:0] comp_addr;
  logic [FAULT_ADDR_WIDTH-1:0]  comp_fault;
  logic [WORD_WIDTH-1:0]        comp_value;
  logic [CNT_W-1:0]             comp_count;

  assign alloc_ready = !reset && !cv_busy && ((alloc_conv ? pending1 : pending0) != CNT_FULL);
  assign alloc_take  = alloc_valid && alloc_ready;

  // Producers only see the port when neither interrupt servicing nor a reservation holds it.
  assign prod_open = !reset && !cv_busy && !alloc_take;
  assign req       = {p1_valid, p0_valid} & {2{prod_open}};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (prod_open),
    .grant   (grant)
  );

  assign p0_ready  = grant[0];
  assign p1_ready  = grant[1];
  assign comp_take = |grant;

  always_comb begin
    comp_conv  = p0_conv;
    comp_addr  = p0_addr;
    comp_fault = p0_fault;
    comp_value = p0_value;
    if (grant[1]) begin
      comp_conv  = p1_conv;
      comp_addr  = p1_addr;
      comp_fault = p1_fault;
      comp_value = p1_value;
    end
    comp_count = comp_conv ? pending1 : pending0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_conv  <= 1'b0;
      wr_addr  <= '0;
      slot_q   <= '0;
      pending0 <= '0;
      pending1 <= '0;
      spurious <= 1'b0;
    end else begin
      wr_en    <= alloc_take || comp_take;
      spurious <= comp_take && (comp_count == '0);
      if (alloc_take) begin
        wr_conv <= alloc_conv;
        wr_addr <= alloc_addr;
        slot_q  <= '{finished: 1'b0, fault: F_NONE, value: '0};
        if (alloc_conv) pending1 <= pending1 + CNT_ONE;
        else            pending0 <= pending0 + CNT_ONE;
      end else if (comp_take) begin
        wr_conv <= comp_conv;
        wr_addr <= comp_addr;
        slot_q  <= '{finished: 1'b1, fault: comp_fault, value: comp_value};
        // A completion with nothing outstanding is still written but leaves the count at zero.
        if (comp_count != '0) begin
          if (comp_conv) pending1 <= pending1 - CNT_ONE;
          else           pending0 <= pending0 - CNT_ONE;
        end
      end
    end
  end

  assign wr_slot = slot_q;
  assign drained = (pending0 == '0) && (pending1 == '0) && !wr_en;

endmodule

// File: tb/tb_conveyor_writeback.sv
// Directed scenarios then randomized traffic, all checked against a behavioural model of the writeback rules.
module tb_conveyor_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0, alloc_conv = 1'b0;
  logic [3:0]  alloc_addr = '0;
  logic        p0_valid = 1'b0, p0_conv = 1'b0, p1_valid = 1'b0, p1_conv = 1'b0;
  logic [3:0]  p0_addr = '0, p1_addr = '0;
  logic [2:0]  p0_fault = '0, p1_fault = '0;
  logic [31:0] p0_value = '0, p1_value = '0;
  logic        cv_busy = 1'b0;
  logic        alloc_ready, p0_ready, p1_ready;
  logic        wr_en, wr_conv, drained, spurious;
  logic [3:0]  wr_addr;
  logic [35:0] wr_slot;
  logic [4:0]  pending0, pending1;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_pend[2];
  int          m_ptr;
  logic        m_wr_en, m_conv, m_spur;
  logic [3:0]  m_addr;
  logic [35:0] m_slot;
  logic        obs_p0;

  always #5 clk = ~clk;

  conveyor_writeback #(.WORD_WIDTH(32), .CONVEYOR_ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_conv(alloc_conv), .alloc_addr(alloc_addr),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_conv(p0_conv), .p0_addr(p0_addr),
    .p0_fault(p0_fault), .p0_value(p0_value),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_conv(p1_conv), .p1_addr(p1_addr),
    .p1_fault(p1_fault), .p1_value(p1_value),
    .cv_busy(cv_busy),
    .wr_en(wr_en), .wr_conv(wr_conv), .wr_addr(wr_addr), .wr_slot(wr_slot),
    .pending0(pending0), .pending1(pending1), .drained(drained), .spurious(spurious)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; cv_busy = 1'b0;
    alloc_valid = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  // One clock: check handshake outputs against the rules, advance the model, check registered outputs.
  task automatic step();
    logic       e_ar, e_alloc, e_open, in_reset;
    logic [1:0] e_g;
    int         k, c;
    #2;
    in_reset = rst;
    e_ar     = !rst && !cv_busy && (m_pend[alloc_conv] != 16);
    e_alloc  = alloc_valid && e_ar;
    e_open   = !rst && !cv_busy && !e_alloc;
    e_g      = 2'b00;
    if (e_open) begin
      if (p0_valid && p1_valid) e_g[m_ptr] = 1'b1;
      else if (p0_valid)        e_g[0] = 1'b1;
      else if (p1_valid)        e_g[1] = 1'b1;
    end
    obs_p0 = p0_ready;
    check("alloc_ready", alloc_ready, e_ar);
    check("p0_ready", p0_ready, e_g[0]);
    check("p1_ready", p1_ready, e_g[1]);

    if (rst) begin
      m_pend[0] = 0; m_pend[1] = 0; m_ptr = 0;
      m_wr_en = 0; m_conv = 0; m_addr = '0; m_slot = '0; m_spur = 0;
    end else begin
      m_wr_en = e_alloc || (e_g != 2'b00);
      m_spur  = 1'b0;
      if (e_alloc) begin
        m_conv = alloc_conv;
        m_addr = alloc_addr;
        m_slot = {1'b0, 3'd0, 32'd0};
        m_pend[alloc_conv] = m_pend[alloc_conv] + 1;
      end else if (e_g != 2'b00) begin
        k      = e_g[1] ? 1 : 0;
        c      = k ? int'(p1_conv) : int'(p0_conv);
        m_conv = k ? p1_conv : p0_conv;
        m_addr = k ? p1_addr : p0_addr;
        m_slot = k ? {1'b1, p1_fault, p1_value} : {1'b1, p0_fault, p0_value};
        if (m_pend[c] == 0) m_spur = 1'b1;
        else                m_pend[c] = m_pend[c] - 1;
        m_ptr = 1 - k;
      end
    end

    @(posedge clk);
    #1;
    check("wr_en", wr_en, m_wr_en);
    if (m_wr_en || in_reset) begin
      check("wr_conv", wr_conv, m_conv);
      check("wr_addr", wr_addr, m_addr);
      check("wr_slot", wr_slot, m_slot);
    end
    check("pending0", pending0, m_pend[0]);
    check("pending1", pending1, m_pend[1]);
    check("spurious", spurious, m_spur);
    check("drained", drained, (m_pend[0] == 0) && (m_pend[1] == 0) && !m_wr_en);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1; alloc_valid = 1'b1; p0_valid = 1'b1; p1_valid = 1'b1;
    step();
    step();
    idle_inputs();
  endtask

  initial begin
    m_pend[0] = 0; m_pend[1] = 0; m_ptr = 0;
    m_wr_en = 0; m_conv = 0; m_addr = '0; m_slot = '0; m_spur = 0;

    do_reset();
    step();
    check("reset_drained", drained, 1'b1);

    // Reserve slot 5 on the main conveyor
    alloc_valid = 1'b1; alloc_conv = 1'b0; alloc_addr = 4'd5;
    step();
    check("alloc_wr_addr", wr_addr, 4'd5);
    check("alloc_pending0", pending0, 5'd1);
    check("alloc_drained", drained, 1'b0);

    // Producer 0 completes it
    idle_inputs();
    p0_valid = 1'b1; p0_conv = 1'b0; p0_addr = 4'd5; p0_fault = 3'd0; p0_value = 32'hDEADBEEF;
    step();
    check("comp_slot", wr_slot, {1'b1, 3'd0, 32'hDEADBEEF});
    check("comp_pending0", pending0, 5'd0);
    idle_inputs();
    step();
    check("comp_drained", drained, 1'b1);

    // Both producers contend with pointer at 0: p0, p1, p0, p1
    do_reset();
    p0_valid = 1'b1; p1_valid = 1'b1; p0_conv = 1'b0; p1_conv = 1'b1;
    p0_addr = 4'd1; p1_addr = 4'd2; p1_fault = 3'd4; p1_value = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_order", obs_p0, (i % 2) == 0);
      check("rr_one_write", wr_en, 1'b1);
    end

    // cv_busy blocks everything; releasing it lets alloc win, then p0
    idle_inputs();
    cv_busy = 1'b1; alloc_valid = 1'b1; alloc_conv = 1'b0; alloc_addr = 4'd9;
    p0_valid = 1'b1; p0_addr = 4'd3; p0_value = 32'hA5A5_0001;
    step();
    check("busy_no_write", wr_en, 1'b0);
    cv_busy = 1'b0;
    step();
    check("busy_alloc_first", wr_slot[35], 1'b0);
    alloc_valid = 1'b0;
    step();
    check("busy_p0_second", wr_slot, {1'b1, 3'd0, 32'hA5A5_0001});

    // Fill conveyor 1, then free one slot
    do_reset();
    alloc_valid = 1'b1; alloc_conv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      alloc_addr = 4'(i);
      step();
    end
    check("full_pending1", pending1, 5'd16);
    check("full_not_ready", alloc_ready, 1'b0);
    step();
    alloc_valid = 1'b0;
    p0_valid = 1'b1; p0_conv = 1'b1; p0_addr = 4'd0;
    step();
    idle_inputs();
    alloc_valid = 1'b1; alloc_conv = 1'b1;
    #1;
    check("refill_ready", alloc_ready, 1'b1);
    step();

    // Spurious completion, then reset with a write in flight
    do_reset();
    p0_valid = 1'b1; p0_conv = 1'b0; p0_addr = 4'd7; p0_fault = 3'd2; p0_value = 32'h0BAD_0BAD;
    step();
    check("spur_write", wr_en, 1'b1);
    check("spur_pulse", spurious, 1'b1);
    check("spur_pending0", pending0, 5'd0);
    idle_inputs();
    step();
    check("spur_once", spurious, 1'b0);
    alloc_valid = 1'b1; alloc_conv = 1'b0; alloc_addr = 4'd2;
    step();
    rst = 1'b1;
    step();
    check("reset_kills_write", wr_en, 1'b0);
    idle_inputs();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      cv_busy     = ($urandom_range(0, 5) == 0);
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_conv  = 1'($urandom);
      alloc_addr  = 4'($urandom);
      p0_valid    = 1'($urandom);
      p0_conv     = 1'($urandom);
      p0_addr     = 4'($urandom);
      p0_fault    = 3'($urandom);
      p0_value    = $urandom;
      p1_valid    = 1'($urandom);
      p1_conv     = 1'($urandom);
      p1_addr     = 4'($urandom);
      p1_fault    = 3'($urandom);
      p1_value    = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
